// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: ALU op encoding, arbiter FSM states and requester count.
package alu_pkg;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } alu_state_e;
endpackage

// File: rtl/ALU_Unit.sv
// Combinational integer ALU shared by both requesters; add/sub wrap modulo 2^Bits.
module ALU_Unit
    import alu_pkg::*;
#(
    parameter int Bits = 64
) (
    input  logic [Bits-1:0] a_i,
    input  logic [Bits-1:0] b_i,
    input  alu_op_e         op_i,
    output logic [Bits-1:0] result_o
);
    always_comb begin
        result_o = '0;
        unique case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin issue sequencer in front of one shared ALU_Unit.
// Define ALU_ARB_PERF_EN to add saturating per-requester grant counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int Bits = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    // Handshake: a transfer happens in any cycle where valid and ready are both high;
    // ready never depends on operand data, and response data stays stable until taken.
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*Bits-1:0] req_a_i,
    input  logic [NUM_REQ*Bits-1:0] req_b_i,
    input  logic [NUM_REQ*2-1:0]    req_sel_i,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    input  logic [NUM_REQ-1:0]      rsp_ready_i,
    output logic [Bits-1:0]         rsp_result_o,
    output logic                    rsp_zero_o,
`ifdef ALU_ARB_PERF_EN
    output logic [31:0]             grant_cnt0_o,
    output logic [31:0]             grant_cnt1_o,
`endif
    output alu_state_e              dbg_state_o
);
    alu_state_e      state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            owner_q, owner_d;
    logic [Bits-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    logic            can_issue, issue, win;
    logic [Bits-1:0] alu_a, alu_b, alu_res;
    alu_op_e         alu_op;

    // A new op may be taken when idle, or when the owner retires its response this cycle.
    always_comb begin
        can_issue   = (state_q == IDLE) || rsp_ready_i[owner_q];
        win         = (req_valid_i == 2'b11) ? ~last_grant_q : req_valid_i[1];
        issue       = can_issue && (|req_valid_i);
        req_ready_o = issue ? {win, ~win} : 2'b00;
        alu_a       = win ? req_a_i[2*Bits-1:Bits] : req_a_i[Bits-1:0];
        alu_b       = win ? req_b_i[2*Bits-1:Bits] : req_b_i[Bits-1:0];
        alu_op      = alu_op_e'(win ? req_sel_i[3:2] : req_sel_i[1:0]);
    end

    ALU_Unit #(.Bits(Bits)) u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .op_i     (alu_op),
        .result_o (alu_res)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        result_d     = result_q;
        zero_d       = zero_q;
        if (issue) begin
            state_d      = RESP;
            last_grant_d = win;
            owner_d      = win;
            result_d     = alu_res;
            zero_d       = (alu_res == '0);
        end else if (state_q == RESP && rsp_ready_i[owner_q]) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
        end
    end

    assign rsp_valid_o  = (state_q == RESP) ? {owner_q, ~owner_q} : 2'b00;
    assign rsp_result_o = result_q;
    assign rsp_zero_o   = zero_q;
    assign dbg_state_o  = state_q;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] grant_cnt0_q, grant_cnt0_d;
    logic [31:0] grant_cnt1_q, grant_cnt1_d;

    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (issue && !win && grant_cnt0_q != 32'hFFFF_FFFF) grant_cnt0_d = grant_cnt0_q + 32'd1;
        if (issue && win && grant_cnt1_q != 32'hFFFF_FFFF)  grant_cnt1_d = grant_cnt1_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0_o = grant_cnt0_q;
    assign grant_cnt1_o = grant_cnt1_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic against a queue-based model.
// Build with ALU_ARB_PERF_EN defined to also exercise the grant counters.
module tb_alu_arbiter;
    import alu_pkg::*;
    localparam int W = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
    logic [2*W-1:0]   req_a_i, req_b_i;
    logic [3:0]       req_sel_i;
    logic [W-1:0]     rsp_result_o;
    logic             rsp_zero_o;
    alu_state_e       dbg_state;
`ifdef ALU_ARB_PERF_EN
    logic [31:0]      grant_cnt0, grant_cnt1;
    logic [31:0]      g_cnt [2];
`endif

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [W-1:0]     exp_q[$];
    int               own_q[$];
    int               m_last;
    logic [W-1:0]     m_result;
    logic             m_zero;
    logic [69:0]      got, want;

    alu_arbiter #(.Bits(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .req_sel_i    (req_sel_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .rsp_zero_o   (rsp_zero_o),
`ifdef ALU_ARB_PERF_EN
        .grant_cnt0_o (grant_cnt0),
        .grant_cnt1_o (grant_cnt1),
`endif
        .dbg_state_o  (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Reference model
    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b, input int sel);
        case (sel)
            0:       return a + b;
            1:       return a - b;
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [1:0] exp_valid();
        if (exp_q.size() == 0) return 2'b00;
        return (own_q[0] == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        own_q.delete();
        m_last   = 1;
        m_result = '0;
        m_zero   = 1'b0;
`ifdef ALU_ARB_PERF_EN
        g_cnt[0] = 0;
        g_cnt[1] = 0;
`endif
    endtask

    task automatic model_expect(output logic [1:0] e_rdy, output int win);
        bit can;
        can   = (exp_q.size() == 0) || rsp_ready_i[own_q[0]];
        win   = -1;
        e_rdy = 2'b00;
        if (can) begin
            if (req_valid_i == 2'b11) win = 1 - m_last;
            else if (req_valid_i[0])  win = 0;
            else if (req_valid_i[1])  win = 1;
        end
        if (win == 0) e_rdy = 2'b01;
        if (win == 1) e_rdy = 2'b10;
    endtask

    task automatic model_clock(input int win);
        logic [W-1:0] r;
        if (exp_q.size() != 0 && rsp_ready_i[own_q[0]]) begin
            void'(exp_q.pop_front());
            void'(own_q.pop_front());
        end
        if (win >= 0) begin
            r = alu_ref(req_a_i[win*W +: W], req_b_i[win*W +: W], int'(req_sel_i[win*2 +: 2]));
            exp_q.push_back(r);
            own_q.push_back(win);
            m_result = r;
            m_zero   = (r == 0);
            m_last   = win;
`ifdef ALU_ARB_PERF_EN
            if (g_cnt[win] != 32'hFFFF_FFFF) g_cnt[win] = g_cnt[win] + 1;
`endif
        end
    endtask

    // Driver tasks
    task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sel);
        req_a_i[r*W +: W] = a;
        req_b_i[r*W +: W] = b;
        req_sel_i[r*2 +: 2] = sel;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] rr);
        req_valid_i = v;
        rsp_ready_i = rr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(2'b00, 2'b00);
        req_a_i = '0;
        req_b_i = '0;
        req_sel_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        got  = {dbg_state == RESP, req_ready_o, rsp_valid_o, rsp_zero_o, rsp_result_o};
        want = '0;
        n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL reset: got %h want %h", got, want); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_tie();
        logic [1:0] e_rdy;
        int win;
        for (int c = 0; c < 6; c++) begin
            set_req(0, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
            set_req(1, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
            drive((c < 4) ? 2'b11 : 2'b00, 2'b11);
            @(negedge clk);
            model_expect(e_rdy, win);
            got  = {dbg_state == RESP, req_ready_o, rsp_valid_o, rsp_zero_o, rsp_result_o};
            want = {exp_q.size() != 0, e_rdy, exp_valid(), m_zero, m_result};
            n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL tie c%0d: got %h want %h", c, got, want); end
            if (c < 4) begin
                n_cmp++;
                if (req_ready_o !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_bad++; $display("FAIL tie_order c%0d: got %b want %b", c, req_ready_o, (c % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            model_clock(win);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_single_issue();
        logic [1:0] e_rdy;
        int win;
        for (int c = 0; c < 3; c++) begin
            set_req(0, 64'd5, 64'd3, 2'b01);
            set_req(1, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
            drive((c == 0) ? 2'b01 : 2'b00, 2'b11);
            @(negedge clk);
            model_expect(e_rdy, win);
            got  = {dbg_state == RESP, req_ready_o, rsp_valid_o, rsp_zero_o, rsp_result_o};
            want = {exp_q.size() != 0, e_rdy, exp_valid(), m_zero, m_result};
            n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL single c%0d: got %h want %h", c, got, want); end
            if (c == 1) begin
                n_cmp++;
                if ({rsp_valid_o, rsp_zero_o, rsp_result_o} !== {2'b01, 1'b0, 64'd2}) begin
                    n_bad++; $display("FAIL single_const: got vld=%b z=%b res=%0d want vld=01 z=0 res=2", rsp_valid_o, rsp_zero_o, rsp_result_o);
                end
            end
            model_clock(win);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_zero_wrap();
        logic [1:0] e_rdy;
        int win;
        for (int c = 0; c < 3; c++) begin
            set_req(1, {W{1'b1}}, 64'd1, 2'b00);
            set_req(0, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
            drive((c == 0) ? 2'b10 : 2'b00, 2'b11);
            @(negedge clk);
            model_expect(e_rdy, win);
            got  = {dbg_state == RESP, req_ready_o, rsp_valid_o, rsp_zero_o, rsp_result_o};
            want = {exp_q.size() != 0, e_rdy, exp_valid(), m_zero, m_result};
            n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL wrap c%0d: got %h want %h", c, got, want); end
            if (c == 1) begin
                n_cmp++;
                if ({rsp_valid_o, rsp_zero_o, rsp_result_o} !== {2'b10, 1'b1, 64'd0}) begin
                    n_bad++; $display("FAIL wrap_const: got vld=%b z=%b res=%h want vld=10 z=1 res=0", rsp_valid_o, rsp_zero_o, rsp_result_o);
                end
            end
            model_clock(win);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] e_rdy;
        int win;
        logic [1:0] v_seq [7]  = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        logic [1:0] rr_seq [7] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b11, 2'b11};
        for (int c = 0; c < 7; c++) begin
            set_req(0, 64'd6, 64'd3, 2'b10);
            set_req(1, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
            drive(v_seq[c], rr_seq[c]);
            @(negedge clk);
            model_expect(e_rdy, win);
            got  = {dbg_state == RESP, req_ready_o, rsp_valid_o, rsp_zero_o, rsp_result_o};
            want = {exp_q.size() != 0, e_rdy, exp_valid(), m_zero, m_result};
            n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL bp c%0d: got %h want %h", c, got, want); end
            if (c >= 1 && c <= 3) begin
                n_cmp++;
                if ({req_ready_o, rsp_valid_o, rsp_result_o} !== {2'b00, 2'b01, 64'd2}) begin
                    n_bad++; $display("FAIL bp_hold c%0d: got rdy=%b vld=%b res=%0d want rdy=00 vld=01 res=2", c, req_ready_o, rsp_valid_o, rsp_result_o);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (req_ready_o !== 2'b10) begin n_bad++; $display("FAIL bp_release: got rdy=%b want 10", req_ready_o); end
            end
            model_clock(win);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_op();
        logic [1:0] e_rdy;
        int win;
        set_req(0, 64'd9, 64'd4, 2'b00);
        drive(2'b01, 2'b00);
        @(negedge clk);
        model_expect(e_rdy, win);
        model_clock(win);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({rsp_valid_o, rsp_zero_o, rsp_result_o} !== {2'b00, 1'b0, 64'd0}) begin
            n_bad++; $display("FAIL rst_mid: got vld=%b z=%b res=%h want vld=00 z=0 res=0", rsp_valid_o, rsp_zero_o, rsp_result_o);
        end
        model_reset();
        drive(2'b11, 2'b11);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_req(0, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
            set_req(1, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
            drive((c == 0) ? 2'b11 : 2'b00, 2'b11);
            @(negedge clk);
            model_expect(e_rdy, win);
            got  = {dbg_state == RESP, req_ready_o, rsp_valid_o, rsp_zero_o, rsp_result_o};
            want = {exp_q.size() != 0, e_rdy, exp_valid(), m_zero, m_result};
            n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL rst_after c%0d: got %h want %h", c, got, want); end
            if (c == 0) begin
                n_cmp++;
                if (req_ready_o !== 2'b01) begin n_bad++; $display("FAIL rst_tie: got rdy=%b want 01", req_ready_o); end
            end
            model_clock(win);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        logic [1:0] e_rdy;
        int win;
        logic [W-1:0] a;
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 2; r++) begin
                a = {$urandom, $urandom};
                set_req(r, a, ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom}, 2'($urandom_range(0, 3)));
            end
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            @(negedge clk);
            model_expect(e_rdy, win);
            got  = {dbg_state == RESP, req_ready_o, rsp_valid_o, rsp_zero_o, rsp_result_o};
            want = {exp_q.size() != 0, e_rdy, exp_valid(), m_zero, m_result};
            n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL random c%0d: got %h want %h", c, got, want); end
            model_clock(win);
            @(posedge clk);
            #1;
        end
        drive(2'b00, 2'b11);
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        own_q.delete();
    endtask

`ifdef ALU_ARB_PERF_EN
    task automatic test_perf();
        logic [1:0] e_rdy;
        int win;
        logic [1:0] v_seq [7] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            set_req(0, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
            set_req(1, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
            drive(v_seq[c], 2'b11);
            @(negedge clk);
            model_expect(e_rdy, win);
            n_cmp++;
            if ({grant_cnt0, grant_cnt1} !== {g_cnt[0], g_cnt[1]}) begin
                n_bad++; $display("FAIL perf c%0d: got %0d/%0d want %0d/%0d", c, grant_cnt0, grant_cnt1, g_cnt[0], g_cnt[1]);
            end
            model_clock(win);
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if ({grant_cnt0, grant_cnt1} !== {32'd3, 32'd2}) begin
            n_bad++; $display("FAIL perf_const: got %0d/%0d want 3/2", grant_cnt0, grant_cnt1);
        end
        force dut.grant_cnt0_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 release dut.grant_cnt0_q;
        drive(2'b01, 2'b11);
        @(posedge clk);
        #1 drive(2'b00, 2'b11);
        @(negedge clk);
        n_cmp++;
        if ({grant_cnt0, grant_cnt1} !== {32'hFFFF_FFFF, 32'd2}) begin
            n_bad++; $display("FAIL perf_sat: got %h/%0d want ffffffff/2", grant_cnt0, grant_cnt1);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_tie();
        test_single_issue();
        test_zero_wrap();
        test_backpressure();
        test_reset_mid_op();
        test_random();
`ifdef ALU_ARB_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and issue sequencer for the shared integer ALU in the RISC-V processor. It accepts operations from requester 0 (execute stage) and requester 1 (address/branch helper) over valid/ready handshakes. It serialises them onto a single ALU instance and returns a registered result and zero flag to the requester that issued the operation. At most one operation is outstanding at a time.

## Interface
- Bits, 64, datapath width of operands and result
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid_i  input  2  per-requester operation valid (bit i = requester i)
- req_ready_o  output  2  per-requester operation accepted when valid&ready
- req_a_i  input  2×Bits  operand A per requester (packed, requester 1 in upper Bits)
- req_b_i  input  2×Bits  operand B per requester
- req_sel_i  input  2×2  ALU op per requester: 00 add, 01 sub, 10 and, 11 or
- rsp_valid_o  output  2  result valid, one-hot to the issuing requester
- rsp_ready_i  input  2  per-requester result acceptance
- rsp_result_o  output  Bits  registered ALU result (shared bus; qualify with rsp_valid_o)
- rsp_zero_o  output  1  registered zero flag of rsp_result_o
- grant_cnt0_o, grant_cnt1_o  output  32 each  saturating grant counters (only with ALU_ARB_PERF_EN)

## Operation
- FSM states: IDLE (no pending response), RESP (response held for owner).
- IDLE: arbitrate among req_valid_i; winner gets req_ready_o high the same cycle (combinational grant). Loser sees ready low.
- Arbitration: one valid wins outright. Both valid: winner is the requester not equal to last_grant. last_grant updates only on an accepted issue.
- On issue: operands and sel of the winner drive the ALU. result, zero flag and owner index are registered. FSM → RESP.
- RESP: rsp_valid_o[owner]=1, other bit 0. result/zero/owner stable until rsp_ready_i[owner].
- RESP with rsp_ready_i[owner]=1: the response retires. In the same cycle, arbitration runs as in IDLE (back-to-back issue allowed). With an issue, stay in RESP with new data. Without one, → IDLE.
- RESP with rsp_ready_i[owner]=0: req_ready_o=00, all state held. rsp_ready_i of the non-owner is ignored.
- Arithmetic: add/sub wrap modulo 2^Bits, no carry/overflow output. zero = (result == all Bits zeros), width-correct for any Bits.
- Undefined sel is impossible (2-bit fully decoded).
- Inputs of a non-granted requester are don't-care and must not affect outputs.

## Timing
- Reset values: state=IDLE, rsp_valid_o=00, rsp_result_o=0, rsp_zero_o=0 (register value), last_grant=1 (requester 0 wins first tie), grant counters=0.
- Reset mid-operation: pending response is discarded immediately (async), no response is ever delivered for it.
- Latency: issue in cycle N → rsp_valid_o high in cycle N+1.
- Throughput: 1 op/cycle when the owner holds rsp_ready_i high.
- req_ready_o is combinational from req_valid_i, rsp_ready_i, state and last_grant. There is no combinational path from operands to any output.

## Configuration
- ALU_ARB_PERF_EN defined: grant_cnt0_o/grant_cnt1_o ports exist. Each increments by 1 on an accepted issue from its requester, saturating at 32'hFFFF_FFFF, and is cleared by rst.
- Not defined: ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package alu_pkg: typedef for the ALU op encoding (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11), the FSM state enum, and NUM_REQ=2.
- One sub-module: the existing combinational ALU_Unit, instantiated once with Bits passed through. The arbiter adds only muxing, registers and FSM.

## Test plan
- Single issue: req0 A=5, B=3, sel=01, rsp_ready=1 → rsp_valid_o=01 next cycle, result=2, zero=0.
- Zero flag and wrap: req1 A=64'hFFFF_FFFF_FFFF_FFFF, B=1, sel=00 → rsp_valid_o=10, result=0, zero=1.
- Tie round-robin: both valid every cycle, rsp_ready=11, 4 cycles → grants 0,1,0,1, with results routed to the matching rsp_valid_o bit.
- Backpressure: req0 issues A=6, B=3, sel=10, rsp_ready_i[0]=0 for 3 cycles while req1 is valid → req_ready_o=00, result=2 held. Release → retire and issue req1 the same cycle.
- Reset mid-op: assert rst while in RESP → rsp_valid_o=00 immediately. After release, the first tie goes to requester 0.
- With ALU_ARB_PERF_EN: 3 issues from req0 and 2 from req1 → grant_cnt0_o=3, grant_cnt1_o=2. Force a counter to 32'hFFFF_FFFF and issue → it stays at 32'hFFFF_FFFF.
